alu_operand_stage: RTL



---
 rtl/alu_operand_stage_if.sv | 11 +
 rtl/alu_operand_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/alu_operand_stage_if.sv
// Valid/ready operand stream between a producer and the operand stage.
interface alu_operand_stage_if #(
    parameter int W = 16
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/alu_operand_stage.sv
// Paired left/right operand FIFOs feeding the ALU; releases matched pairs only.
// Optional occupancy/skew counters: ALU_OPERAND_STAGE_STATS_EN.
module alu_operand_stage #(
    parameter int LVAL_SIZE = 16,
    parameter int RVAL_SIZE = 16,
    parameter int DEPTH     = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  s_lval_axis,
    alu_operand_stage_if.slave  s_rval_axis,
    alu_operand_stage_if.master m_lval_axis,
    alu_operand_stage_if.master m_rval_axis
`ifdef ALU_OPERAND_STAGE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0] lval_level,
    output logic [$clog2(DEPTH):0] rval_level,
    output logic [31:0]            skew_cycles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C1   = CW'(1);
    localparam logic [PW-1:0] P1   = PW'(1);

    logic [LVAL_SIZE-1:0] mem_l_q [DEPTH];
    logic [RVAL_SIZE-1:0] mem_r_q [DEPTH];

    logic [PW-1:0] wr_l_q, wr_l_d, rd_l_q, rd_l_d;
    logic [PW-1:0] wr_r_q, wr_r_d, rd_r_q, rd_r_d;
    logic [CW-1:0] cnt_l_q, cnt_l_d, cnt_r_q, cnt_r_d;

    logic ne_l, ne_r, pair_vld;
    logic push_l, pop_l, push_r, pop_r;

    // Readies and valid come from registered counts only, so no
    // combinational path crosses the buffer in either direction.
    always_comb begin
        ne_l     = cnt_l_q != '0;
        ne_r     = cnt_r_q != '0;
        pair_vld = ne_l && ne_r;

        s_lval_axis.tready = cnt_l_q != FULL;
        s_rval_axis.tready = cnt_r_q != FULL;
        m_lval_axis.tvalid = pair_vld;
        m_rval_axis.tvalid = pair_vld;
        m_lval_axis.tdata  = ne_l ? mem_l_q[rd_l_q] : '0;
        m_rval_axis.tdata  = ne_r ? mem_r_q[rd_r_q] : '0;

        push_l = s_lval_axis.tvalid && (cnt_l_q != FULL);
        push_r = s_rval_axis.tvalid && (cnt_r_q != FULL);
        pop_l  = pair_vld && m_lval_axis.tready;
        pop_r  = pair_vld && m_rval_axis.tready;
    end

    always_comb begin
        wr_l_d  = push_l ? wr_l_q + P1 : wr_l_q;
        rd_l_d  = pop_l  ? rd_l_q + P1 : rd_l_q;
        wr_r_d  = push_r ? wr_r_q + P1 : wr_r_q;
        rd_r_d  = pop_r  ? rd_r_q + P1 : rd_r_q;
        cnt_l_d = cnt_l_q;
        cnt_r_d = cnt_r_q;
        unique case ({push_l, pop_l})
            2'b10:   cnt_l_d = cnt_l_q + C1;
            2'b01:   cnt_l_d = cnt_l_q - C1;
            default: cnt_l_d = cnt_l_q;
        endcase
        unique case ({push_r, pop_r})
            2'b10:   cnt_r_d = cnt_r_q + C1;
            2'b01:   cnt_r_d = cnt_r_q - C1;
            default: cnt_r_d = cnt_r_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_l_q  <= '0;
            rd_l_q  <= '0;
            cnt_l_q <= '0;
            wr_r_q  <= '0;
            rd_r_q  <= '0;
            cnt_r_q <= '0;
        end else begin
            wr_l_q  <= wr_l_d;
            rd_l_q  <= rd_l_d;
            cnt_l_q <= cnt_l_d;
            wr_r_q  <= wr_r_d;
            rd_r_q  <= rd_r_d;
            cnt_r_q <= cnt_r_d;
        end
    end

    // Storage is not reset; emptiness is tracked by the counts alone.
    always_ff @(posedge clk) begin
        if (push_l) mem_l_q[wr_l_q] <= s_lval_axis.tdata;
        if (push_r) mem_r_q[wr_r_q] <= s_rval_axis.tdata;
    end

`ifdef ALU_OPERAND_STAGE_STATS_EN
    logic [31:0] skew_q, skew_d;

    always_comb begin
        skew_d = skew_q;
        if ((ne_l ^ ne_r) && (skew_q != '1)) skew_d = skew_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) skew_q <= '0;
        else     skew_q <= skew_d;
    end

    assign lval_level  = cnt_l_q;
    assign rval_level  = cnt_r_q;
    assign skew_cycles = skew_q;
`endif

endmodule
